// File: rtl/alu_res_station.sv
// ALU reservation station: in-order age queue with CDB wakeup, oldest-ready select
// and a registered issue port toward the single-cycle ALU.
package alu_res_station_pkg;
    localparam logic [6:0]  OP_AUIPC = 7'b0010111;
    localparam int unsigned RS_TAG_W = 8;
    localparam int unsigned RS_ROB_W = 8;

    typedef struct packed {
        logic                alu_output_valid;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [31:0]         pc;
        logic [32:0]         imm_val;
        logic [RS_TAG_W-1:0] pr1_s;
        logic [RS_TAG_W-1:0] pr2_s;
        logic [RS_TAG_W-1:0] prd_s;
        logic [RS_ROB_W-1:0] rob_id;
        logic [31:0]         rs1_val;
        logic [31:0]         rs2_val;
    } res_station_alu_out_s;
endpackage

module alu_res_station
    import alu_res_station_pkg::*;
#(
    parameter int unsigned NO_PHY_REGS = 64,
    parameter int unsigned PHY_WIDTH   = $clog2(NO_PHY_REGS),
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ROB_WIDTH   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 dispatch_valid,
    output logic                 dispatch_ready,
    input  logic [6:0]           dispatch_opcode,
    input  logic [2:0]           dispatch_funct3,
    input  logic [6:0]           dispatch_funct7,
    input  logic [31:0]          dispatch_pc,
    input  logic [32:0]          dispatch_imm_val,
    input  logic [PHY_WIDTH-1:0] dispatch_pr1_s,
    input  logic [PHY_WIDTH-1:0] dispatch_pr2_s,
    input  logic [PHY_WIDTH-1:0] dispatch_prd_s,
    input  logic                 dispatch_ps1_ready,
    input  logic                 dispatch_ps2_ready,
    input  logic [ROB_WIDTH-1:0] dispatch_rob_id,
    input  logic                 cdb_valid,
    input  logic [PHY_WIDTH-1:0] cdb_prd_s,
    output res_station_alu_out_s exec_arith_rs
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                 r1;
        logic                 r2;
        logic [6:0]           opcode;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [31:0]          pc;
        logic [32:0]          imm_val;
        logic [PHY_WIDTH-1:0] pr1;
        logic [PHY_WIDTH-1:0] pr2;
        logic [PHY_WIDTH-1:0] prd;
        logic [ROB_WIDTH-1:0] rob;
    } entry_t;

    logic [DEPTH-1:0]   valid_q, valid_n;
    entry_t [DEPTH-1:0] ent_q, ent_w, ent_n;
    logic [CNT_W-1:0]   count_q, count_n, sel, wr_idx;
    logic               found, issue, accept;
    entry_t             sel_ent, new_ent;
    res_station_alu_out_s out_issue;

    assign dispatch_ready = rst_n && (count_q < CNT_W'(DEPTH)) && !flush;
    assign accept         = dispatch_valid && dispatch_ready;
    assign issue          = found && !flush;
    assign wr_idx         = issue ? count_q - 1'b1 : count_q;

    // Operand readiness at write includes a same-cycle CDB bypass.
    always_comb begin
        new_ent         = '0;
        new_ent.opcode  = dispatch_opcode;
        new_ent.funct3  = dispatch_funct3;
        new_ent.funct7  = dispatch_funct7;
        new_ent.pc      = dispatch_pc;
        new_ent.imm_val = dispatch_imm_val;
        new_ent.pr1     = dispatch_pr1_s;
        new_ent.pr2     = dispatch_pr2_s;
        new_ent.prd     = dispatch_prd_s;
        new_ent.rob     = dispatch_rob_id;
        new_ent.r1      = dispatch_ps1_ready || (dispatch_pr1_s == '0) ||
                          (dispatch_opcode == OP_AUIPC) ||
                          (cdb_valid && (cdb_prd_s == dispatch_pr1_s));
        new_ent.r2      = dispatch_ps2_ready || (dispatch_pr2_s == '0) ||
                          dispatch_imm_val[32] || (dispatch_opcode == OP_AUIPC) ||
                          (cdb_valid && (cdb_prd_s == dispatch_pr2_s));
    end

    always_comb begin
        found   = 1'b0;
        sel     = '0;
        sel_ent = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!found && valid_q[i] && ent_q[i].r1 && ent_q[i].r2) begin
                found   = 1'b1;
                sel     = CNT_W'(i);
                sel_ent = ent_q[i];
            end
        end
    end

    always_comb begin
        ent_w = ent_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (cdb_valid && valid_q[i]) begin
                if (ent_q[i].pr1 == cdb_prd_s) ent_w[i].r1 = 1'b1;
                if (ent_q[i].pr2 == cdb_prd_s) ent_w[i].r2 = 1'b1;
            end
        end
        ent_n   = ent_w;
        valid_n = valid_q;
        // Entries above the issued slot compact down; the top slot always empties.
        if (issue) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                if (CNT_W'(i) >= sel) begin
                    ent_n[i]   = ent_w[i+1];
                    valid_n[i] = valid_q[i+1];
                end
            end
            valid_n[DEPTH-1] = 1'b0;
        end
        if (accept) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    ent_n[i]   = new_ent;
                    valid_n[i] = 1'b1;
                end
            end
        end
        count_n = count_q + CNT_W'(accept) - CNT_W'(issue);
    end

    always_comb begin
        out_issue                  = '0;
        out_issue.alu_output_valid = 1'b1;
        out_issue.opcode           = sel_ent.opcode;
        out_issue.funct3           = sel_ent.funct3;
        out_issue.funct7           = sel_ent.funct7;
        out_issue.pc               = sel_ent.pc;
        out_issue.imm_val          = sel_ent.imm_val;
        out_issue.pr1_s            = RS_TAG_W'(sel_ent.pr1);
        out_issue.pr2_s            = RS_TAG_W'(sel_ent.pr2);
        out_issue.prd_s            = RS_TAG_W'(sel_ent.prd);
        out_issue.rob_id           = RS_ROB_W'(sel_ent.rob);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            ent_q         <= '0;
            count_q       <= '0;
            exec_arith_rs <= '0;
        end else if (flush) begin
            valid_q                        <= '0;
            count_q                        <= '0;
            exec_arith_rs.alu_output_valid <= 1'b0;
        end else begin
            valid_q <= valid_n;
            ent_q   <= ent_n;
            count_q <= count_n;
            if (issue) exec_arith_rs <= out_issue;
            else       exec_arith_rs.alu_output_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_res_station.sv
// Randomized scoreboard bench for alu_res_station against a list-based station model.
module tb_alu_res_station;
    import alu_res_station_pkg::*;

    localparam int unsigned PW    = 6;
    localparam int unsigned RW    = 5;
    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [6:0]    opcode;
        logic [2:0]    f3;
        logic [6:0]    f7;
        logic [31:0]   pc;
        logic [32:0]   imm;
        logic [PW-1:0] pr1, pr2, prd;
        logic [RW-1:0] rob;
        logic          r1, r2;
    } instr_t;

    typedef struct {
        logic   valid;
        instr_t ins;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, dispatch_valid = 1'b0;
    logic dispatch_ready;
    logic cdb_valid = 1'b0;
    logic [PW-1:0] cdb_prd_s = '0;
    instr_t din;
    res_station_alu_out_s exec_arith_rs;

    instr_t pend[$];
    exp_t   exp_q[$];
    int     errors = 0, checks = 0;

    alu_res_station #(.NO_PHY_REGS(64), .PHY_WIDTH(PW), .DEPTH(DEPTH), .ROB_WIDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_opcode(din.opcode), .dispatch_funct3(din.f3), .dispatch_funct7(din.f7),
        .dispatch_pc(din.pc), .dispatch_imm_val(din.imm),
        .dispatch_pr1_s(din.pr1), .dispatch_pr2_s(din.pr2), .dispatch_prd_s(din.prd),
        .dispatch_ps1_ready(din.r1), .dispatch_ps2_ready(din.r2),
        .dispatch_rob_id(din.rob),
        .cdb_valid(cdb_valid), .cdb_prd_s(cdb_prd_s),
        .exec_arith_rs(exec_arith_rs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_valid", 64'(exec_arith_rs.alu_output_valid), 64'(e.valid));
            if (e.valid && exec_arith_rs.alu_output_valid) begin
                check("opcode", 64'(exec_arith_rs.opcode), 64'(e.ins.opcode));
                check("funct3", 64'(exec_arith_rs.funct3), 64'(e.ins.f3));
                check("funct7", 64'(exec_arith_rs.funct7), 64'(e.ins.f7));
                check("pc", 64'(exec_arith_rs.pc), 64'(e.ins.pc));
                check("imm_val", 64'(exec_arith_rs.imm_val), 64'(e.ins.imm));
                check("pr1_s", 64'(exec_arith_rs.pr1_s), 64'(e.ins.pr1));
                check("pr2_s", 64'(exec_arith_rs.pr2_s), 64'(e.ins.pr2));
                check("prd_s", 64'(exec_arith_rs.prd_s), 64'(e.ins.prd));
                check("rob_id", 64'(exec_arith_rs.rob_id), 64'(e.ins.rob));
                check("operand_vals_zero",
                      64'({exec_arith_rs.rs1_val, exec_arith_rs.rs2_val}), 64'(0));
            end
        end
    end

    // One clock of stimulus plus the model's view of what the issue port shows after the edge.
    task automatic step(input logic f, input logic dv, input instr_t ins,
                        input logic cv, input logic [PW-1:0] ct);
        exp_t   e;
        instr_t n;
        int     hit;
        logic   model_rdy;
        @(negedge clk);
        #1;
        flush = f; dispatch_valid = dv; din = ins; cdb_valid = cv; cdb_prd_s = ct;
        #1;
        model_rdy = (pend.size() < DEPTH) && !f;
        check("dispatch_ready", 64'(dispatch_ready), 64'(model_rdy));
        e.valid = 1'b0;
        e.ins   = ins;
        if (f) begin
            pend.delete();
        end else begin
            hit = -1;
            foreach (pend[i]) if (hit < 0 && pend[i].r1 && pend[i].r2) hit = i;
            if (hit >= 0) begin
                e.valid = 1'b1;
                e.ins   = pend[hit];
                pend.delete(hit);
            end
            if (cv) foreach (pend[i]) begin
                if (pend[i].pr1 == ct) pend[i].r1 = 1'b1;
                if (pend[i].pr2 == ct) pend[i].r2 = 1'b1;
            end
            if (dv && model_rdy) begin
                n    = ins;
                n.r1 = ins.r1 || ins.pr1 == 0 || ins.opcode == OP_AUIPC || (cv && ct == ins.pr1);
                n.r2 = ins.r2 || ins.pr2 == 0 || ins.imm[32] || ins.opcode == OP_AUIPC ||
                       (cv && ct == ins.pr2);
                pend.push_back(n);
            end
        end
        exp_q.push_back(e);
    endtask

    function automatic instr_t mk(input logic [6:0] op, input logic [PW-1:0] p1, input logic r1,
                                  input logic [PW-1:0] p2, input logic r2, input logic [32:0] imm,
                                  input logic [PW-1:0] pd, input logic [RW-1:0] rob);
        instr_t n;
        n.opcode = op; n.f3 = 3'(rob); n.f7 = 7'h20; n.pc = 32'h1000 + 32'(rob) * 4;
        n.imm = imm; n.pr1 = p1; n.r1 = r1; n.pr2 = p2; n.r2 = r2; n.prd = pd; n.rob = rob;
        return n;
    endfunction

    function automatic instr_t rand_instr();
        instr_t n;
        case ($urandom_range(3))
            0:       n.opcode = 7'b0110011;
            1:       n.opcode = 7'b0010011;
            2:       n.opcode = OP_AUIPC;
            default: n.opcode = 7'b0110111;
        endcase
        n.f3  = 3'($urandom);
        n.f7  = 7'($urandom);
        n.pc  = $urandom;
        n.imm = {1'($urandom_range(3) == 0), $urandom};
        n.pr1 = PW'($urandom_range(7));
        n.pr2 = PW'($urandom_range(7));
        n.prd = PW'($urandom);
        n.rob = RW'($urandom);
        n.r1  = ($urandom_range(3) == 0);
        n.r2  = ($urandom_range(3) == 0);
        return n;
    endfunction

    task automatic idle(input int unsigned cycles);
        instr_t z;
        z = mk(7'h13, '0, 1'b0, '0, 1'b0, '0, '0, '0);
        for (int unsigned i = 0; i < cycles; i++) step(1'b0, 1'b0, z, 1'b0, '0);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        #1;
        rst_n = 1'b0; dispatch_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
        #1;
        check("reset_out_zero", 64'(exec_arith_rs == '0), 64'(1));
        check("reset_dispatch_ready", 64'(dispatch_ready), 64'(0));
        pend.delete();
        e.valid = 1'b0;
        e.ins   = din;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 64'(dispatch_ready), 64'(1));
        exp_q.push_back(e);
    endtask

    initial begin
        instr_t t;
        din = mk(7'h13, '0, 1'b0, '0, 1'b0, '0, '0, '0);
        do_reset();

        // ADDI with immediate operand: minimum-latency issue
        step(1'b0, 1'b1, mk(7'b0010011, 6'd5, 1'b1, 6'd3, 1'b0, 33'h1_0000_0004, 6'd9, 5'd3),
             1'b0, '0);
        idle(3);

        // ADD waiting on tag 7, woken two cycles later
        step(1'b0, 1'b1, mk(7'b0110011, 6'd5, 1'b1, 6'd7, 1'b0, '0, 6'd10, 5'd1), 1'b0, '0);
        idle(1);
        t = mk(7'h13, '0, 1'b0, '0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b0, t, 1'b1, 6'd7);
        idle(3);

        // Fill all slots waiting on tag 12, then release together
        for (int unsigned i = 0; i < DEPTH; i++)
            step(1'b0, 1'b1, mk(7'b0110011, 6'd12, 1'b0, 6'd12, 1'b0, '0, 6'd20, RW'(i)),
                 1'b0, '0);
        step(1'b0, 1'b1, mk(7'b0110011, 6'd1, 1'b1, 6'd2, 1'b1, '0, 6'd21, 5'd30), 1'b0, '0);
        step(1'b0, 1'b0, t, 1'b1, 6'd12);
        idle(10);

        // Dispatch coinciding with the broadcast of its second source
        step(1'b0, 1'b1, mk(7'b0110011, 6'd3, 1'b1, 6'd7, 1'b0, '0, 6'd11, 5'd4), 1'b1, 6'd7);
        idle(3);

        // Flush of four waiting entries; later broadcast must wake nothing
        for (int unsigned i = 0; i < 4; i++)
            step(1'b0, 1'b1, mk(7'b0110011, 6'd20, 1'b0, 6'd2, 1'b1, '0, 6'd22, RW'(i + 8)),
                 1'b0, '0);
        step(1'b1, 1'b1, mk(7'b0110011, 6'd1, 1'b1, 6'd2, 1'b1, '0, 6'd23, 5'd15), 1'b0, '0);
        idle(1);
        step(1'b0, 1'b0, t, 1'b1, 6'd20);
        idle(3);

        // Reset while three entries have just become ready
        for (int unsigned i = 0; i < 3; i++)
            step(1'b0, 1'b1, mk(7'b0110011, 6'd25, 1'b0, 6'd25, 1'b0, '0, 6'd24, RW'(i + 16)),
                 1'b0, '0);
        step(1'b0, 1'b0, t, 1'b1, 6'd25);
        do_reset();
        idle(3);

        for (int unsigned i = 0; i < 1500; i++)
            step($urandom_range(39) == 0, $urandom_range(2) != 0, rand_instr(),
                 1'($urandom_range(1)), PW'($urandom_range(7)));
        for (int unsigned i = 0; i < 40; i++) step(1'b0, 1'b0, t, 1'b1, PW'(i % 8));
        check("model_drained", 64'(pend.size()), 64'(0));

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_res_station.md
ALU_RES_STATION -- requirements
Module: alu_res_station

Interface
REQ-001 Parameter NO_PHY_REGS, default 64, number of physical registers.
REQ-002 Parameter PHY_WIDTH, default $clog2(NO_PHY_REGS), physical tag width.
REQ-003 Parameter DEPTH, default 8, number of station entries.
REQ-004 Parameter ROB_WIDTH, default 5, ROB index width.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 flush  input  1  squash all entries and any pending issue.
REQ-008 dispatch_valid  input  1  rename presents an ALU instruction this cycle.
REQ-009 dispatch_ready  output  1  station can accept a dispatch this cycle.
REQ-010 dispatch_opcode/funct3/funct7  input  7/3/7  decoded instruction fields.
REQ-011 dispatch_pc  input  32  instruction PC.
REQ-012 dispatch_imm_val  input  33  bit 32 = operand-2-is-immediate, bits 31:0 immediate.
REQ-013 dispatch_pr1_s, dispatch_pr2_s, dispatch_prd_s  input  PHY_WIDTH each  source/destination tags.
REQ-014 dispatch_ps1_ready, dispatch_ps2_ready  input  1 each  source already available in PRF.
REQ-015 dispatch_rob_id  input  ROB_WIDTH  ROB slot.
REQ-016 cdb_valid  input  1  result broadcast this cycle.
REQ-017 cdb_prd_s  input  PHY_WIDTH  tag being broadcast.
REQ-018 exec_arith_rs  output  res_station_alu_out_s  issued op: alu_output_valid, opcode, funct3, funct7, pc, imm_val, pr1_s, pr2_s, prd_s, rob_id; all other fields 0.

Function
REQ-019 Entries held in allocation order, index 0 oldest; valid entries always contiguous from index 0.
REQ-020 dispatch_ready SHALL be 1 iff valid-entry count < DEPTH and flush = 0; a simultaneous issue does not free a slot for that cycle's dispatch.
REQ-021 Dispatch accepted when dispatch_valid & dispatch_ready; entry written at next edge at index (count minus 1 if an issue occurs that edge, else count).
REQ-022 Source-1 ready at write = dispatch_ps1_ready | pr1_s==0 | opcode==op_auipc | (cdb_valid & cdb_prd_s==pr1_s).
REQ-023 Source-2 ready at write = dispatch_ps2_ready | pr2_s==0 | imm_val[32] | opcode==op_auipc | (cdb_valid & cdb_prd_s==pr2_s).
REQ-024 Wakeup: each valid entry whose pending source tag equals cdb_prd_s with cdb_valid=1 SHALL set that ready bit at the next edge.
REQ-025 Select: lowest-index valid entry with both ready bits set, evaluated on registered ready bits only (wakeup-to-issue >= 1 cycle).
REQ-026 Selected entry SHALL be loaded into the exec_arith_rs register at the next edge with alu_output_valid=1; entries above it shift down one index the same edge.
REQ-027 With no ready entry, exec_arith_rs.alu_output_valid SHALL be 0 next cycle; other fields hold.
REQ-028 At most one issue and one dispatch per cycle; both may occur on the same edge.
REQ-029 Minimum latency: dispatch with both sources ready at edge E0 -> alu_output_valid=1 in the cycle after edge E1.
REQ-030 No back-pressure from execution: the consumer is single-cycle and always accepts.
REQ-031 flush=1 SHALL clear all entry valid bits and alu_output_valid at the next edge; dispatch and issue ignored that cycle.

Reset
REQ-032 rst_n=0 SHALL immediately clear all entry valid and ready bits, count to 0, and exec_arith_rs to all-zero.
REQ-033 dispatch_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after deassertion.
REQ-034 Reset asserted mid-operation discards all entries; no issue occurs on the following edge.

Verification
REQ-035 Dispatch ADDI (pr1=5 ready, imm_val=33'h1_0000_0004, prd=9, rob=3) at E0 -> cycle after E1: alu_output_valid=1, prd_s=9, rob_id=3, imm_val[32]=1.
REQ-036 Dispatch ADD pr1=5 ready, pr2=7 not ready; cdb_valid with tag 7 two cycles later -> issue exactly one cycle after the broadcast edge, never earlier.
REQ-037 Fill 8 entries all waiting on tag 12 -> dispatch_ready=0; broadcast tag 12 -> issues in rob_id order 0..7, one per cycle, dispatch_ready returns 1 after the first issue edge.
REQ-038 Dispatch with pr2=7 in the same cycle cdb broadcasts 7 -> entry written ready, issues at minimum latency.
REQ-039 Four waiting entries, flush=1 for one cycle -> count 0, alu_output_valid=0 next cycle, later broadcast of their tags causes no issue.
REQ-040 rst_n low for one cycle while three entries ready -> exec_arith_rs zero immediately, no issue after release, dispatch_ready=1.
